// File: rtl/uart_tx_mmio_if.sv
// Memory-mapped bus between the MIPS datapath (master) and the UART transmitter (slave).
// Handshake: a store or load is a single-cycle strobe qualified by address_i; the slave is always ready.
interface uart_tx_mmio_if;
    logic        mem_write_i;
    logic        mem_read_i;
    logic [31:0] address_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;
    logic        sel_o;

    modport master (
        output mem_write_i,
        output mem_read_i,
        output address_i,
        output write_data_i,
        input  read_data_o,
        input  sel_o
    );

    modport slave (
        input  mem_write_i,
        input  mem_read_i,
        input  address_i,
        input  write_data_i,
        output read_data_o,
        output sel_o
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO fed by stores, 8N1 serialiser, status register.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter logic [31:0] DATA_ADDR    = 32'h10010400,
    parameter logic [31:0] STAT_ADDR    = 32'h10010404,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_mmio_if.slave  bus,
    output logic           tx_o,
    output logic           busy_o,
    output logic [2:0]     state_dbg
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    // Address decode and bus strobes
    logic data_hit, stat_hit;
    logic push_hit, ovf_clr;
    logic unused_wdata;

    assign data_hit     = (bus.address_i == DATA_ADDR);
    assign stat_hit     = (bus.address_i == STAT_ADDR);
    assign push_hit     = bus.mem_write_i & data_hit;
    assign ovf_clr      = bus.mem_write_i & stat_hit & bus.write_data_i[2];
    assign unused_wdata = ^bus.write_data_i[31:8];

    // FIFO storage and occupancy
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_n;
    logic          full, empty;
    logic          do_push, pop;
    logic          overflow;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Fullness is judged before this edge's pop, so a store on a full FIFO is dropped.
    assign do_push = push_hit & ~full;

    always_comb begin
        count_n = count;
        unique case ({do_push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.write_data_i[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_n;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_hit && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serialiser FSM
    state_t     state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shift, shift_n;
    logic       tx_n, busy_n;
    logic       par;

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n   = bit_idx + 1'b1;
                        shift_n = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase

        // Line level follows the state being entered so tx_o is glitch-free from a flop.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par;
`endif
            default: tx_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE) || (count_n != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx_o     <= tx_n;
            busy_o   <= busy_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured from the whole byte at pop, before the shifter consumes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par <= 1'b0;
        end else if (pop) begin
            par <= ^mem[rd_ptr];
        end
    end
`else
    assign par = 1'b0;
`endif

    // Status read path: combinational, no side effects
    assign bus.read_data_o = (bus.mem_read_i && stat_hit) ?
                             {28'b0, empty, overflow, full, busy_o} : 32'b0;
    assign bus.sel_o       = data_hit | stat_hit;
    assign state_dbg       = state;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=8), with a line monitor.
module tb_uart_tx_mmio;

    localparam int CPB = 4;
    localparam logic [31:0] DATA_ADDR = 32'h10010400;
    localparam logic [31:0] STAT_ADDR = 32'h10010404;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    // clock / reset
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_o, busy_o;
    logic [2:0] state_dbg;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .DATA_ADDR   (DATA_ADDR),
        .STAT_ADDR   (STAT_ADDR),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx_o     (tx_o),
        .busy_o   (busy_o),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // scoreboard state
    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];
    logic       saw_reset = 1'b0;

    always @(posedge reset) saw_reset = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // driver tasks
    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.mem_write_i  = 1'b1;
        bus.address_i    = a;
        bus.write_data_i = d;
        @(posedge clk);
        #1;
        bus.mem_write_i  = 1'b0;
        bus.address_i    = '0;
        bus.write_data_i = '0;
    endtask

    task automatic lw_stat(output logic [31:0] v);
        @(negedge clk);
        bus.mem_read_i = 1'b1;
        bus.address_i  = STAT_ADDR;
        #1;
        v = bus.read_data_o;
        bus.mem_read_i = 1'b0;
        bus.address_i  = '0;
    endtask

    // Cycle-exact line check, starting at the first negedge after the pop edge.
    task automatic frame_check(input logic [7:0] b, input string tag);
        logic e;
        for (int j = 1; j <= NBITS * CPB; j++) begin
            int k;
            @(negedge clk);
            k = (j - 1) / CPB;
            if (k == 0)              e = 1'b0;
            else if (k <= 8)         e = b[k-1];
            else if (k == NBITS - 1) e = 1'b1;
            else                     e = ^b;
            check(tag, {31'b0, tx_o}, {31'b0, e});
        end
    endtask

    // Line monitor: decodes frames mid-bit and scores them against exp_q.
    initial begin : monitor
        logic       prev, st, pb, sp;
        logic [7:0] b;
        prev = 1'b1;
        pb   = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && prev && !tx_o) begin
                saw_reset = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                st = tx_o;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx_o;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                pb = tx_o;
`endif
                repeat (CPB) @(negedge clk);
                sp = tx_o;
                if (!saw_reset) begin
                    check("mon_start", {31'b0, st}, 32'd0);
                    check("mon_stop", {31'b0, sp}, 32'd1);
`ifdef UART_TX_PARITY_EN
                    check("mon_parity", {31'b0, pb}, {31'b0, ^b});
`endif
                    if (exp_q.size() == 0) check("mon_unexpected_byte", {24'b0, b}, 32'hFFFF_FFFF);
                    else check("mon_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
                end
            end
            prev = tx_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // main stimulus
    initial begin
        logic [31:0] v;
        int n;
        int lows;
        bus.mem_write_i  = 1'b0;
        bus.mem_read_i   = 1'b0;
        bus.address_i    = '0;
        bus.write_data_i = '0;

        // 1: reset and idle
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_tx", {31'b0, tx_o}, 32'd1);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_state", {29'b0, state_dbg}, 32'd0);
        lw_stat(v);
        check("rst_status", v, 32'h8);

        // address decode and read gating
        @(negedge clk);
        bus.address_i = DATA_ADDR;
        #1 check("sel_data", {31'b0, bus.sel_o}, 32'd1);
        bus.address_i = STAT_ADDR;
        #1 check("sel_stat", {31'b0, bus.sel_o}, 32'd1);
        check("rd_no_strobe", bus.read_data_o, 32'h0);
        bus.address_i  = 32'h10010408;
        bus.mem_read_i = 1'b1;
        #1 check("sel_other", {31'b0, bus.sel_o}, 32'd0);
        check("rd_other_addr", bus.read_data_o, 32'h0);
        bus.mem_read_i = 1'b0;
        bus.address_i  = '0;

        // 2: single frame 0xA5, exact timing
        exp_q.push_back(8'hA5);
        sw(DATA_ADDR, 32'h0000_00A5);
        @(negedge clk);
        check("t2_tx_before_pop", {31'b0, tx_o}, 32'd1);
        check("t2_busy_queued", {31'b0, busy_o}, 32'd1);
        frame_check(8'hA5, "t2_line");
        check("t2_busy_in_stop", {31'b0, busy_o}, 32'd1);
        @(negedge clk);
        check("t2_busy_after", {31'b0, busy_o}, 32'd0);
        check("t2_tx_after", {31'b0, tx_o}, 32'd1);

        // 3: burst of 9 stores, then a 10th that overflows
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'(8'h30 + i));
            sw(DATA_ADDR, 32'h30 + i);
        end
        sw(DATA_ADDR, 32'h39);
        lw_stat(v);
        check("t3_status_full", v, 32'h7);
        n = 0;
        while (busy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t3_drain_in_time", {31'b0, (n < 2000)}, 32'd1);
        check("t3_all_received", exp_q.size(), 32'd0);
        lw_stat(v);
        check("t3_ovf_sticky", v, 32'hC);

        // 4: overflow clear only with bit 2 set; reads are side-effect free
        sw(STAT_ADDR, 32'h3);
        lw_stat(v);
        check("t4_no_clear", v, 32'hC);
        sw(STAT_ADDR, 32'h4);
        lw_stat(v);
        check("t4_cleared_1", v, 32'h8);
        lw_stat(v);
        check("t4_cleared_2", v, 32'h8);

        // 6 (runs in both builds): back-to-back 0x07 then 0x03
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        sw(DATA_ADDR, 32'h07);
        sw(DATA_ADDR, 32'h03);
        frame_check(8'h07, "t6_frame07");
        @(negedge clk);
        check("t6_gap_tx", {31'b0, tx_o}, 32'd1);
        check("t6_gap_busy", {31'b0, busy_o}, 32'd1);
        check("t6_gap_state", {29'b0, state_dbg}, 32'd0);
        frame_check(8'h03, "t6_frame03");
        @(negedge clk);
        check("t6_busy_after", {31'b0, busy_o}, 32'd0);

        // 5: reset during DATA bit 3 of 0xFF with a second byte queued
        sw(DATA_ADDR, 32'hFF);
        sw(DATA_ADDR, 32'hFF);
        repeat (18) @(negedge clk);
        check("t5_in_data", {29'b0, state_dbg}, 32'd2);
        bus.mem_read_i = 1'b1;
        bus.address_i  = STAT_ADDR;
        #2 reset = 1'b1;
        #1;
        check("t5_tx_async", {31'b0, tx_o}, 32'd1);
        check("t5_busy_async", {31'b0, busy_o}, 32'd0);
        check("t5_state_async", {29'b0, state_dbg}, 32'd0);
        check("t5_status_empty", bus.read_data_o, 32'h8);
        bus.mem_read_i = 1'b0;
        bus.address_i  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tx_o || busy_o) lows++;
        end
        check("t5_no_more_frames", lows, 32'd0);
        lw_stat(v);
        check("t5_status_after", v, 32'h8);

        check("sb_empty_at_end", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
